seq_buffer_ctrl: RTL and testbench
==================================

Name: seq_buffer_ctrl

Overview:
- Parametrised target-sequence buffer controller for the Smith-Waterman array.
- Packs a streamed symbol sequence into single-port SRAM words; each word holds SYM_PER_WORD slots of {symbol, payload} plus a header.
- Serves pipelined circular reads and write-backs to the PE array, and clears all payload fields on init.
- Sits between top-level load logic, the DataProcessor and an external single-port SRAM macro, which is driven through ports.

Parameters:
- SYM_W, 2: bits per symbol.
- SLOT_W, 36: bits per slot; the symbol occupies the top SYM_W bits and the payload the rest.
- SYM_PER_WORD, 7: slots per word.
- HDR_W, 4: header width. Bit [HDR_W-1] is the valid bit; the low bits are the used-slot count of the last word, with 0 meaning full.
- WORD_W, HDR_W+SYM_PER_WORD*SLOT_W (256): SRAM word width.
- ADDR_W, 10: SRAM address width.
- LEN_W, 13: width of the sequence-length counter.
- SRAM_LAT, 1: cycles from a CEN-low read to valid sram_q.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- i_init  in  1  pulse; clear the payload of every stored word
- s_valid  in  1  load symbol valid
- s_ready  out  1  load symbol accepted
- s_sym  in  SYM_W  load symbol
- s_last  in  1  final symbol of the sequence
- s_start  in  1  pulse; discard the stored sequence and begin a load
- rd_req  in  1  read request
- rd_ready  out  1  request accepted this cycle
- rd_valid  out  1  rd_data valid
- rd_data  out  WORD_W  word read
- wr_valid  in  1  write-back valid, always accepted
- wr_data  in  WORD_W-HDR_W  payload+symbol fields to store
- o_busy  out  1  load or init in progress
- o_len  out  LEN_W  stored symbol count
- o_overflow  out  1  sticky; a load exceeded capacity
- sram_cen, sram_wen  out  1  active-low chip and write enables
- sram_a  out  ADDR_W  address
- sram_d  out  WORD_W  write data
- sram_q  in  WORD_W  read data

Behaviour:
- Reset values:
  - s_ready, rd_ready, rd_valid, o_busy, o_overflow: 0.
  - rd_data, o_len: 0.
  - sram_cen, sram_wen: 1.
  - sram_a, sram_d: 0.
  - All internal pointers and the state are cleared; state is IDLE.
- Reset mid-operation aborts any load or init; SRAM contents are undefined afterwards.
- All SRAM outputs are registered.
- States: IDLE, LOAD, INIT_RD, INIT_WAIT, INIT_WR.
- IDLE:
  - s_start moves to LOAD and zeroes o_len, last_addr, the pack buffer and o_overflow.
  - i_init moves to INIT_RD from address 0, unless o_len=0, in which case it is ignored.
  - If i_init and s_start arrive together, i_init wins and s_start is dropped.
- LOAD:
  - s_ready=1 and o_busy=1.
  - Each accepted symbol is placed in the next slot of the pack buffer, filling the top slot first, with payload 0; o_len increments.
  - Slot full, or s_last: write the word at the current address.
  - Header of a non-final word: {1, 0}. Header of the final word: {1, used count mod SYM_PER_WORD}.
  - On s_last: last_addr = current address, return to IDLE.
  - If a word fills at address 2^ADDR_W-1 without s_last: write it as final, set o_overflow, return to IDLE.
  - Further symbols in IDLE see s_ready=0.
- Reads (IDLE only, o_len>0):
  - rd_ready = rd_req & ~wr_valid.
  - An accepted request reads rd_ptr; rd_ptr then advances, wrapping to 0 after last_addr.
  - rd_valid and rd_data appear exactly SRAM_LAT+1 cycles after acceptance.
  - Back-to-back requests are accepted every cycle, so data is fully pipelined.
- Write-back (IDLE):
  - wr_valid writes {stored header of wr_ptr, wr_data} to wr_ptr.
  - wr_ptr wraps at last_addr identically to rd_ptr.
  - The header is kept in a per-controller register for the last word only; other words take header {1, 0}.
  - A write has priority over a read in the same cycle.
- Init:
  - INIT_RD issues a read.
  - INIT_WAIT waits SRAM_LAT cycles.
  - INIT_WR writes the word back with its header and symbols kept and all payload bits zeroed, then advances.
  - After last_addr is written: return to IDLE and reset rd_ptr and wr_ptr to 0.
  - o_busy=1 throughout; rd_ready=0; wr_valid is ignored.
- o_busy falls in the same cycle the state register returns to IDLE.

Optional Feature:
- Macro: SEQBUF_PERF_CNT_EN.
- Defined: adds ports o_rd_cnt and o_wr_cnt, both out, 16 bits.
  - They count accepted reads and write-backs, saturate at 16'hFFFF, and clear on rst and on s_start.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Load 7 symbols {0,1,2,3,0,1,2} with s_last on the 7th -> one write to address 0 with header 4'b1000; o_len=7; last_addr=0; o_busy low the next cycle.
- Load 16 symbols -> three words written at addresses 0,1,2; header of word 2 = 4'b1010; o_len=16.
- With 3 stored words, rd_req held for 5 cycles -> rd_valid on 5 consecutive cycles from cycle 2, addresses 0,1,2,0,1.
- wr_valid and rd_req in the same cycle -> rd_ready=0, SRAM write to wr_ptr; the read is accepted on the next cycle.
- i_init after write-backs of nonzero payload -> every word reads back with the same symbols and header and all payloads 0; rd_ptr=0.
- Load with ADDR_W=2 and 40 symbols, no s_last -> 4 words written; o_overflow=1; o_len=28; s_ready=0 afterwards.

Source files
------------

// File: rtl/seq_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_buffer_ctrl
// Purpose  : Packs a streamed target sequence into single-port SRAM words and
//            serves circular pipelined reads / write-backs to the PE array.
// Options  : SEQBUF_PERF_CNT_EN adds saturating read / write-back counters.
// Revision : 1.0 - initial release
// ============================================================================
module seq_buffer_ctrl #(
    parameter int SYM_W        = 2,
    parameter int SLOT_W       = 36,
    parameter int SYM_PER_WORD = 7,
    parameter int HDR_W        = 4,
    parameter int WORD_W       = HDR_W + SYM_PER_WORD*SLOT_W,
    parameter int ADDR_W       = 10,
    parameter int LEN_W        = 13,
    parameter int SRAM_LAT     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_init,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [SYM_W-1:0]         s_sym,
    input  logic                     s_last,
    input  logic                     s_start,
    input  logic                     rd_req,
    output logic                     rd_ready,
    output logic                     rd_valid,
    output logic [WORD_W-1:0]        rd_data,
    input  logic                     wr_valid,
    input  logic [WORD_W-HDR_W-1:0]  wr_data,
    output logic                     o_busy,
    output logic [LEN_W-1:0]         o_len,
    output logic                     o_overflow,
`ifdef SEQBUF_PERF_CNT_EN
    output logic [15:0]              o_rd_cnt,
    output logic [15:0]              o_wr_cnt,
`endif
    output logic                     sram_cen,
    output logic                     sram_wen,
    output logic [ADDR_W-1:0]        sram_a,
    output logic [WORD_W-1:0]        sram_d,
    input  logic [WORD_W-1:0]        sram_q
);

    localparam int c_PAY_W   = SLOT_W - SYM_W;
    localparam int c_DATA_W  = WORD_W - HDR_W;
    localparam int c_SLOT_CW = $clog2(SYM_PER_WORD + 1);
    localparam int c_WAIT_W  = $clog2(SRAM_LAT + 1);
    localparam logic [ADDR_W-1:0] c_ADDR_MAX = '1;
    localparam logic [HDR_W-1:0]  c_HDR_FULL = {1'b1, {(HDR_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_INIT_RD   = 3'd2,
        S_INIT_WAIT = 3'd3,
        S_INIT_WR   = 3'd4
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [LEN_W-1:0]        r_len;
    logic                    r_ovf;
    logic [ADDR_W-1:0]       r_last_addr, r_rd_ptr, r_wr_ptr, r_ld_addr, r_init_addr;
    logic [c_SLOT_CW-1:0]    r_slot;
    logic [c_DATA_W-1:0]     r_buf;
    logic [HDR_W-1:0]        r_last_hdr;
    logic [c_WAIT_W-1:0]     r_wait_cnt;
    logic [SRAM_LAT:0]       r_rd_pipe;
    logic                    r_cen, r_wen;
    logic [ADDR_W-1:0]       r_a;
    logic [WORD_W-1:0]       r_d;

    logic                    w_idle, w_wr_acc, w_rd_acc, w_init_go, w_start_go;
    logic                    w_sym_acc, w_slot_full, w_word_done, w_ovf_hit, w_final;
    logic                    w_init_last;
    logic [HDR_W-2:0]        w_used;
    logic [HDR_W-1:0]        w_ld_hdr, w_wb_hdr;
    logic [c_DATA_W-1:0]     w_buf_nxt;
    logic [WORD_W-1:0]       w_init_word;

    assign w_idle      = (r_state == S_IDLE);
    assign w_wr_acc    = w_idle & wr_valid;
    assign w_rd_acc    = w_idle & (r_len != '0) & rd_req & ~wr_valid;
    assign w_init_go   = w_idle & i_init & (r_len != '0);
    assign w_start_go  = w_idle & s_start & ~w_init_go;
    assign w_sym_acc   = (r_state == S_LOAD) & s_valid;
    assign w_slot_full = (r_slot == c_SLOT_CW'(SYM_PER_WORD-1));
    assign w_word_done = w_sym_acc & (w_slot_full | s_last);
    assign w_ovf_hit   = w_sym_acc & w_slot_full & ~s_last & (r_ld_addr == c_ADDR_MAX);
    assign w_final     = s_last | w_ovf_hit;
    assign w_used      = w_slot_full ? '0 : (HDR_W-1)'(r_slot + 1'b1);
    assign w_ld_hdr    = w_final ? {1'b1, w_used} : c_HDR_FULL;
    assign w_wb_hdr    = (r_wr_ptr == r_last_addr) ? r_last_hdr : c_HDR_FULL;
    assign w_init_last = (r_init_addr == r_last_addr);

    // Slot 0 of the stream lands in the most significant slot of the word.
    always_comb begin
        w_buf_nxt = r_buf;
        for (int i = 0; i < SYM_PER_WORD; i++) begin
            if (r_slot == c_SLOT_CW'(SYM_PER_WORD-1-i))
                w_buf_nxt[i*SLOT_W +: SLOT_W] = {s_sym, {c_PAY_W{1'b0}}};
        end
    end

    always_comb begin
        w_init_word = sram_q;
        for (int i = 0; i < SYM_PER_WORD; i++)
            w_init_word[i*SLOT_W +: c_PAY_W] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_init_go)       w_state_nxt = S_INIT_RD;
                else if (w_start_go) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (w_word_done && w_final) w_state_nxt = S_IDLE;
            end
            S_INIT_RD:   w_state_nxt = S_INIT_WAIT;
            S_INIT_WAIT: begin
                if (r_wait_cnt == c_WAIT_W'(SRAM_LAT-1)) w_state_nxt = S_INIT_WR;
            end
            S_INIT_WR:   w_state_nxt = w_init_last ? S_IDLE : S_INIT_RD;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len       <= '0;
            r_ovf       <= 1'b0;
            r_last_addr <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_ld_addr   <= '0;
            r_init_addr <= '0;
            r_slot      <= '0;
            r_buf       <= '0;
            r_last_hdr  <= '0;
            r_wait_cnt  <= '0;
            r_rd_pipe   <= '0;
            r_cen       <= 1'b1;
            r_wen       <= 1'b1;
            r_a         <= '0;
            r_d         <= '0;
        end else begin
            r_cen     <= 1'b1;
            r_wen     <= 1'b1;
            r_rd_pipe <= {r_rd_pipe[SRAM_LAT-1:0], w_rd_acc};
            case (r_state)
                S_IDLE: begin
                    if (w_wr_acc) begin
                        r_cen    <= 1'b0;
                        r_wen    <= 1'b0;
                        r_a      <= r_wr_ptr;
                        r_d      <= {w_wb_hdr, wr_data};
                        r_wr_ptr <= (r_wr_ptr == r_last_addr) ? '0 : r_wr_ptr + 1'b1;
                    end else if (w_rd_acc) begin
                        r_cen    <= 1'b0;
                        r_a      <= r_rd_ptr;
                        r_rd_ptr <= (r_rd_ptr == r_last_addr) ? '0 : r_rd_ptr + 1'b1;
                    end
                    if (w_init_go) begin
                        r_init_addr <= '0;
                    end else if (w_start_go) begin
                        r_len       <= '0;
                        r_ovf       <= 1'b0;
                        r_last_addr <= '0;
                        r_rd_ptr    <= '0;
                        r_wr_ptr    <= '0;
                        r_ld_addr   <= '0;
                        r_slot      <= '0;
                        r_buf       <= '0;
                        r_last_hdr  <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_sym_acc) begin
                        r_len <= r_len + 1'b1;
                        if (w_word_done) begin
                            r_cen  <= 1'b0;
                            r_wen  <= 1'b0;
                            r_a    <= r_ld_addr;
                            r_d    <= {w_ld_hdr, w_buf_nxt};
                            r_buf  <= '0;
                            r_slot <= '0;
                            if (w_final) begin
                                r_last_addr <= r_ld_addr;
                                r_last_hdr  <= w_ld_hdr;
                                if (w_ovf_hit) r_ovf <= 1'b1;
                            end else begin
                                r_ld_addr <= r_ld_addr + 1'b1;
                            end
                        end else begin
                            r_buf  <= w_buf_nxt;
                            r_slot <= r_slot + 1'b1;
                        end
                    end
                end
                S_INIT_RD: begin
                    r_cen      <= 1'b0;
                    r_a        <= r_init_addr;
                    r_wait_cnt <= '0;
                end
                S_INIT_WAIT: r_wait_cnt <= r_wait_cnt + 1'b1;
                S_INIT_WR: begin
                    r_cen <= 1'b0;
                    r_wen <= 1'b0;
                    r_a   <= r_init_addr;
                    r_d   <= w_init_word;
                    if (w_init_last) begin
                        r_rd_ptr <= '0;
                        r_wr_ptr <= '0;
                    end else begin
                        r_init_addr <= r_init_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SEQBUF_PERF_CNT_EN
    logic [15:0] r_rd_cnt, r_wr_cnt;
    always_ff @(posedge clk) begin
        if (rst || w_start_go) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_rd_acc && (r_rd_cnt != 16'hFFFF)) r_rd_cnt <= r_rd_cnt + 16'd1;
            if (w_wr_acc && (r_wr_cnt != 16'hFFFF)) r_wr_cnt <= r_wr_cnt + 16'd1;
        end
    end
    assign o_rd_cnt = r_rd_cnt;
    assign o_wr_cnt = r_wr_cnt;
`endif

    assign s_ready    = (r_state == S_LOAD);
    assign o_busy     = ~w_idle;
    assign rd_ready   = w_rd_acc;
    assign rd_valid   = r_rd_pipe[SRAM_LAT];
    assign rd_data    = rd_valid ? sram_q : '0;
    assign o_len      = r_len;
    assign o_overflow = r_ovf;
    assign sram_cen   = r_cen;
    assign sram_wen   = r_wen;
    assign sram_a     = r_a;
    assign sram_d     = r_d;

endmodule
`default_nettype wire

// File: tb/tb_seq_buffer_ctrl.sv
`default_nettype none
// Bench for seq_buffer_ctrl: randomized loads, reads, write-backs and inits
// checked every cycle against a word-level behavioural model.
module tb_seq_buffer_ctrl;

    localparam int SYM_W    = 2;
    localparam int SLOT_W   = 36;
    localparam int SPW      = 7;
    localparam int HDR_W    = 4;
    localparam int WORD_W   = HDR_W + SPW*SLOT_W;
    localparam int DATA_W   = WORD_W - HDR_W;
    localparam int PAY_W    = SLOT_W - SYM_W;
    localparam int ADDR_W   = 2;
    localparam int NWORDS   = 1 << ADDR_W;
    localparam int LEN_W    = 13;
    localparam int SRAM_LAT = 1;

    logic clk = 1'b0, rst = 1'b1, rst_q = 1'b1;
    logic i_init = 0, s_valid = 0, s_last = 0, s_start = 0, rd_req = 0, wr_valid = 0;
    logic [SYM_W-1:0]  s_sym = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic s_ready, rd_ready, rd_valid, o_busy, o_overflow, sram_cen, sram_wen;
    logic [WORD_W-1:0] rd_data, sram_d, sram_q;
    logic [LEN_W-1:0]  o_len;
    logic [ADDR_W-1:0] sram_a;
`ifdef SEQBUF_PERF_CNT_EN
    logic [15:0] o_rd_cnt, o_wr_cnt;
`endif

    seq_buffer_ctrl #(.SYM_W(SYM_W), .SLOT_W(SLOT_W), .SYM_PER_WORD(SPW), .HDR_W(HDR_W),
                      .WORD_W(WORD_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .SRAM_LAT(SRAM_LAT)) dut (
        .clk(clk), .rst(rst), .i_init(i_init), .s_valid(s_valid), .s_ready(s_ready),
        .s_sym(s_sym), .s_last(s_last), .s_start(s_start), .rd_req(rd_req),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .wr_valid(wr_valid),
        .wr_data(wr_data), .o_busy(o_busy), .o_len(o_len), .o_overflow(o_overflow),
`ifdef SEQBUF_PERF_CNT_EN
        .o_rd_cnt(o_rd_cnt), .o_wr_cnt(o_wr_cnt),
`endif
        .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_a(sram_a), .sram_d(sram_d),
        .sram_q(sram_q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rst_q <= rst;

    // Single-port SRAM with one cycle of read latency
    logic [WORD_W-1:0] mem [NWORDS];
    initial begin
        for (int w = 0; w < NWORDS; w++) mem[w] = '0;
        sram_q = '0;
    end
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_wen) mem[sram_a] <= sram_d;
            else           sram_q      <= mem[sram_a];
        end
    end

    int n_checks = 0, n_err = 0, cyc = 0;

    task automatic chk(input string nm, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int due; logic [WORD_W-1:0] data; } rd_exp_t;
    int  m_mode = 0;              // 0 idle, 1 loading, 2 init
    int  m_init_cnt = 0, m_len = 0, m_last = 0, m_rdp = 0, m_wrp = 0, m_ld_addr = 0;
    bit  m_ovf = 0;
    logic [HDR_W-1:0]  m_last_hdr = '0;
    logic [WORD_W-1:0] m_mem [NWORDS];
    logic [SYM_W-1:0]  m_pack [$];
    rd_exp_t           m_rdq [$];

    function automatic logic [WORD_W-1:0] make_word(input logic [HDR_W-1:0] hdr);
        logic [WORD_W-1:0] w;
        w = '0;
        w[WORD_W-1 -: HDR_W] = hdr;
        foreach (m_pack[k]) w[DATA_W-1-k*SLOT_W -: SYM_W] = m_pack[k];
        return w;
    endfunction

    function automatic logic [WORD_W-1:0] clear_pay(input logic [WORD_W-1:0] w_in);
        logic [WORD_W-1:0] w;
        w = w_in;
        for (int s = 0; s < SPW; s++) w[s*SLOT_W +: PAY_W] = '0;
        return w;
    endfunction

    always @(negedge clk) begin
        logic e_rdr, e_rdv, ovf_hit, fin;
        logic [HDR_W-1:0] hdr;
        rd_exp_t ent;
        cyc++;
        if (rst_q) begin
            chk("rst_s_ready", s_ready, 0);   chk("rst_rd_ready", rd_ready, 0);
            chk("rst_rd_valid", rd_valid, 0); chk("rst_busy", o_busy, 0);
            chk("rst_overflow", o_overflow, 0); chk("rst_rd_data", rd_data, 0);
            chk("rst_len", o_len, 0);         chk("rst_cen", sram_cen, 1);
            chk("rst_wen", sram_wen, 1);      chk("rst_a", sram_a, 0);
            chk("rst_d", sram_d, 0);
        end
        e_rdr = (m_mode == 0) && (m_len > 0) && rd_req && !wr_valid;
        e_rdv = (m_rdq.size() > 0) && (m_rdq[0].due == cyc);
        if (!rst_q) begin
            chk("busy", o_busy, m_mode != 0);
            chk("s_ready", s_ready, m_mode == 1);
            chk("rd_ready", rd_ready, e_rdr);
            chk("rd_valid", rd_valid, e_rdv);
            if (e_rdv) chk("rd_data", rd_data, m_rdq[0].data);
            chk("o_len", o_len, m_len);
            chk("o_overflow", o_overflow, m_ovf);
        end
        while (m_rdq.size() > 0 && m_rdq[0].due <= cyc) void'(m_rdq.pop_front());

        if (rst) begin
            m_mode = 0; m_len = 0; m_last = 0; m_rdp = 0; m_wrp = 0; m_ld_addr = 0;
            m_ovf = 0; m_last_hdr = '0; m_pack.delete(); m_rdq.delete();
        end else if (m_mode == 0) begin
            if (wr_valid) begin
                hdr = (m_wrp == m_last) ? m_last_hdr : 4'b1000;
                m_mem[m_wrp] = {hdr, wr_data};
                m_wrp = (m_wrp == m_last) ? 0 : m_wrp + 1;
            end else if (e_rdr) begin
                ent.due  = cyc + SRAM_LAT + 1;
                ent.data = m_mem[m_rdp];
                m_rdq.push_back(ent);
                m_rdp = (m_rdp == m_last) ? 0 : m_rdp + 1;
            end
            if (i_init && m_len > 0) begin
                for (int w = 0; w <= m_last; w++) m_mem[w] = clear_pay(m_mem[w]);
                m_mode = 2;
                m_init_cnt = (SRAM_LAT + 2) * (m_last + 1);
            end else if (s_start) begin
                m_mode = 1; m_len = 0; m_last = 0; m_ovf = 0; m_rdp = 0; m_wrp = 0;
                m_ld_addr = 0; m_last_hdr = '0; m_pack.delete();
            end
        end else if (m_mode == 1) begin
            if (s_valid) begin
                m_pack.push_back(s_sym);
                m_len++;
                if (m_pack.size() == SPW || s_last) begin
                    ovf_hit = (m_pack.size() == SPW) && !s_last && (m_ld_addr == NWORDS-1);
                    fin     = s_last || ovf_hit;
                    hdr     = fin ? {1'b1, 3'(m_pack.size() % SPW)} : 4'b1000;
                    m_mem[m_ld_addr] = make_word(hdr);
                    m_pack.delete();
                    if (fin) begin
                        m_last = m_ld_addr; m_last_hdr = hdr; m_mode = 0;
                        if (ovf_hit) m_ovf = 1;
                    end else begin
                        m_ld_addr++;
                    end
                end
            end
        end else begin
            m_init_cnt--;
            if (m_init_cnt == 0) begin m_mode = 0; m_rdp = 0; m_wrp = 0; end
        end
    end

    // ---------------- stimulus ----------------
    int sq [$];

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_mode != 0 && n < 500) begin tick(); n++; end
        if (m_mode != 0) begin
            n_checks++; n_err++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", n);
        end
        tick(); tick();
    endtask

    task automatic load(input bit with_last, input int gap_pct);
        s_start = 1; tick(); s_start = 0;
        foreach (sq[i]) begin
            while ($urandom_range(99) < gap_pct) tick();
            s_valid = 1; s_sym = SYM_W'(sq[i]);
            s_last = with_last && (i == sq.size() - 1);
            tick();
            s_valid = 0; s_last = 0;
        end
        wait_idle();
    endtask

    task automatic rand_seq(input int n);
        sq.delete();
        for (int i = 0; i < n; i++) sq.push_back(int'($urandom_range(3)));
    endtask

    task automatic rand_wdata();
        logic [255:0] t;
        for (int j = 0; j < 8; j++) t[j*32 +: 32] = $urandom;
        wr_data = t[DATA_W-1:0];
    endtask

    task automatic read_burst(input int n, output int nv);
        nv = 0;
        for (int k = 0; k < n + 4; k++) begin
            rd_req = (k < n);
            if (rd_valid) nv++;
            tick();
        end
        rd_req = 0;
    endtask

    task automatic traffic(input int n);
        for (int c = 0; c < n; c++) begin
            rd_req   = ($urandom_range(99) < 60);
            wr_valid = ($urandom_range(99) < 30);
            rand_wdata();
            tick();
        end
        rd_req = 0; wr_valid = 0;
        tick(); tick(); tick();
    endtask

    task automatic do_init();
        i_init = 1; tick(); i_init = 0;
        wait_idle();
    endtask

    task automatic check_mem();
        for (int w = 0; w <= m_last; w++) chk("mem_word", mem[w], m_mem[w]);
    endtask

    initial begin
        int nv;
        for (int w = 0; w < NWORDS; w++) m_mem[w] = '0;
        repeat (3) tick();
        rst = 0; tick();

        // init with nothing stored must be ignored
        do_init();

        sq = '{0, 1, 2, 3, 0, 1, 2};
        load(1, 0);
        chk("t1_len", o_len, 7);
        chk("t1_word0", mem[0], {4'b1000, 2'd0, 34'd0, 2'd1, 34'd0, 2'd2, 34'd0, 2'd3, 34'd0,
                                 2'd0, 34'd0, 2'd1, 34'd0, 2'd2, 34'd0});

        rand_seq(16);
        load(1, 25);
        chk("t2_len", o_len, 16);
        chk("t2_hdr0", mem[0][WORD_W-1 -: HDR_W], 4'b1000);
        chk("t2_hdr2", mem[2][WORD_W-1 -: HDR_W], 4'b1010);
        check_mem();

        read_burst(5, nv);
        chk("t3_valid_cnt", nv, 5);

        rd_req = 1; wr_valid = 1; rand_wdata(); #1;
        chk("t4_rdy_blocked", rd_ready, 0);
        tick(); wr_valid = 0; #1;
        chk("t4_rdy_next", rd_ready, 1);
        tick(); rd_req = 0;
        repeat (3) tick();

        traffic(40);
        check_mem();
        // init and start together: init wins
        i_init = 1; s_start = 1; tick(); i_init = 0; s_start = 0;
        wait_idle();
        check_mem();
        read_burst(7, nv);

        for (int it = 0; it < 6; it++) begin
            rand_seq(int'($urandom_range(1, SPW*NWORDS)));
            load(1, 20);
            traffic(30);
            do_init();
            check_mem();
            read_burst(6, nv);
            traffic(10);
            check_mem();
        end

        rand_seq(40);
        load(0, 0);
        chk("t6_overflow", o_overflow, 1);
        chk("t6_len", o_len, 28);
        chk("t6_s_ready", s_ready, 0);
        chk("t6_hdr3", mem[3][WORD_W-1 -: HDR_W], 4'b1000);
        check_mem();
        read_burst(5, nv);

        // reset in the middle of a load
        rand_seq(20);
        s_start = 1; tick(); s_start = 0;
        for (int i = 0; i < 5; i++) begin s_valid = 1; s_sym = SYM_W'(sq[i]); tick(); end
        s_valid = 0; rst = 1; tick(); tick(); rst = 0; tick();
        chk("t7_busy", o_busy, 0);
        chk("t7_len", o_len, 0);

        rand_seq(10);
        load(1, 10);
        chk("t8_overflow", o_overflow, 0);
        check_mem();
        read_burst(4, nv);
        traffic(20);
        check_mem();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
